if_fetch_unit: RTL and testbench

//  Instruction fetch front end of the RV32IM pipeline. Keeps the fetch PC and issues in-order

---
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit.sv | 139 +++++++++++++
 tb/tb_if_fetch_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, EX redirect, and IF/ID output.
// master = fetch unit, slave = surrounding pipeline/memory.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_fault;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, if_fault,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, if_fault,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/if_fetch_unit.sv
// RV32IM instruction fetch front end: in-order imem requests, small PC/word queue, redirect flush.
// Optional IF_MISALIGN_CHECK_EN: misaligned redirect targets queue a single faulting NOP entry.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  if_fetch_unit_if.master    bus
);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IF_MISALIGN_CHECK_EN
  typedef enum logic {RUN, FAULT} state_t;
`else
  typedef enum logic {RUN} state_t;
`endif

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc;
  logic [31:0]     q_pc   [FIFO_DEPTH];
  logic [31:0]     q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_filled;
  logic [AW-1:0]   head, tail, fill_ptr;
  logic [AW:0]     count, pend, drop_cnt, drop_next;
  logic            accept, fill, discard, pop, if_valid;

  assign bus.imem_req  = !RESET && (state == RUN) && !bus.redirect
                         && ((count + drop_cnt) < (AW+1)'(FIFO_DEPTH));
  assign bus.imem_addr = fetch_pc;

  assign accept  = bus.imem_req && bus.imem_ready;
  assign fill    = bus.imem_rvalid && !bus.redirect && (drop_cnt == '0);
  assign discard = bus.imem_rvalid && !bus.redirect && (drop_cnt != '0);
  assign if_valid = (count != '0) && q_filled[head];
  assign pop     = if_valid && !bus.stall && !bus.redirect;

  // Every response still owed to the flushed entries must be dropped; one arriving
  // in the redirect cycle itself is consumed right here and not counted.
  always_comb begin
    drop_next = drop_cnt + pend;
    if (bus.imem_rvalid && (drop_next != '0))
      drop_next = drop_next - (AW+1)'(1);
  end

`ifdef IF_MISALIGN_CHECK_EN
  logic fault_load;
  assign fault_load = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
`endif

  always_comb begin
    state_nxt = state;
    if (bus.redirect) begin
`ifdef IF_MISALIGN_CHECK_EN
      state_nxt = fault_load ? FAULT : RUN;
`else
      state_nxt = RUN;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      q_filled <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      head     <= '0;
      pend     <= '0;
      drop_cnt <= drop_next;
`ifdef IF_MISALIGN_CHECK_EN
      if (fault_load) begin
        tail     <= AW'(1);
        fill_ptr <= AW'(1);
        count    <= (AW+1)'(1);
        q_filled <= FIFO_DEPTH'(1);
      end else begin
        tail     <= '0;
        fill_ptr <= '0;
        count    <= '0;
        q_filled <= '0;
      end
`else
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      q_filled <= '0;
`endif
    end else begin
      if (accept) begin
        tail           <= tail + AW'(1);
        fetch_pc       <= fetch_pc + 32'd4;
        q_filled[tail] <= 1'b0;
      end
      if (fill) begin
        fill_ptr           <= fill_ptr + AW'(1);
        q_filled[fill_ptr] <= 1'b1;
      end
      if (pop) head <= head + AW'(1);
      if (discard) drop_cnt <= drop_cnt - (AW+1)'(1);
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
      pend  <= pend + (AW+1)'(accept) - (AW+1)'(fill);
    end
  end

  // Queue payload needs no reset: validity is carried by count/q_filled.
  always_ff @(posedge CLK) begin
    if (accept) q_pc[tail] <= fetch_pc;
    if (fill)   q_data[fill_ptr] <= bus.imem_rdata;
`ifdef IF_MISALIGN_CHECK_EN
    if (fault_load) begin
      q_pc[0]   <= bus.redirect_pc;
      q_data[0] <= NOP;
    end
`endif
  end

  assign bus.if_valid    = if_valid;
  assign bus.if_pc       = if_valid ? q_pc[head] : '0;
  assign bus.if_pc_plus4 = bus.if_pc + 32'd4;
  assign bus.if_instr    = if_valid ? q_data[head] : NOP;
`ifdef IF_MISALIGN_CHECK_EN
  assign bus.if_fault    = if_valid && (state == FAULT);
`else
  assign bus.if_fault    = 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: in-order memory model with variable latency and a
// scoreboard of expected (pc, instr, fault) outputs regenerated from each redirect target.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] exp_next, exp_addr;
  logic        fault_mode = 1'b0;
  int          errors = 0, checks = 0, pops = 0;
  int          p_stall = 0, p_ready = 100, p_red = 0, lat_min = 1, lat_max = 1;
  logic        force_red = 1'b0, force_stall = 1'b0;
  logic [31:0] force_pc = '0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void refill();
    exp_t n;
    if (!fault_mode)
      while (exp_q.size() < 8) begin
        n.pc = exp_next; n.instr = mem_word(exp_next); n.fault = 1'b0;
        exp_q.push_back(n);
        exp_next = exp_next + 32'd4;
      end
  endfunction

  function automatic void model_redirect(logic [31:0] t);
    exp_q.delete();
    fault_mode = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    if (t[1:0] != 2'b00) begin
      exp_t n;
      n.pc = t; n.instr = NOP; n.fault = 1'b1;
      exp_q.push_back(n);
      fault_mode = 1'b1;
    end
`endif
    exp_next = t & 32'hFFFF_FFFC;
    exp_addr = exp_next;
    refill();
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    fault_mode = 1'b0;
    exp_next = RESET_PC;
    exp_addr = RESET_PC;
    refill();
  endfunction

  function automatic logic [31:0] rand_target();
    int unsigned r = $urandom_range(0, 15);
    if (r == 0) return 32'hFFFF_FFFC;
    if (r == 1) return ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
    return $urandom_range(0, 1023) << 2;
  endfunction

  // Monitor: observes each cycle's handshakes just before the edge that acts on them.
  always @(negedge clk) begin
    if (!rst) begin
      if (fault_mode) check32("req_in_fault", 32'(bus.imem_req), 32'd0);
      if (bus.imem_req && bus.imem_ready) begin
        check32("imem_addr", bus.imem_addr, exp_addr);
        check32("inflight_limit", 32'(mem_addr_q.size() < DEPTH), 32'd1);
        exp_addr = exp_addr + 32'd4;
        mem_addr_q.push_back(bus.imem_addr);
        mem_due_q.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
      end
      if (bus.imem_rvalid && mem_addr_q.size() > 0) begin
        void'(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end
      if (bus.if_valid && !bus.stall && !bus.redirect) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got pc %08h expected no output", bus.if_pc);
        end else begin
          e = exp_q.pop_front();
          check32("if_pc", bus.if_pc, e.pc);
          check32("if_pc_plus4", bus.if_pc_plus4, e.pc + 32'd4);
          check32("if_instr", bus.if_instr, e.instr);
          check32("if_fault", 32'(bus.if_fault), 32'(e.fault));
        end
      end
      if (bus.redirect) begin
        check32("req_during_redirect", 32'(bus.imem_req), 32'd0);
        model_redirect(bus.redirect_pc);
      end
      if (!bus.if_valid) begin
        check32("idle_instr", bus.if_instr, NOP);
        check32("idle_fault", 32'(bus.if_fault), 32'd0);
      end
      refill();
    end
  end

  task automatic step();
    @(posedge clk); #1;
    bus.imem_ready = ($urandom_range(0, 99) < p_ready);
    bus.stall      = force_stall || ($urandom_range(0, 99) < p_stall);
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(mem_addr_q[0]);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    if (force_red) begin
      bus.redirect    = 1'b1;
      bus.redirect_pc = force_pc;
      force_red       = 1'b0;
    end else if ($urandom_range(0, 99) < p_red) begin
      bus.redirect    = 1'b1;
      bus.redirect_pc = rand_target();
    end else begin
      bus.redirect    = 1'b0;
      bus.redirect_pc = $urandom;
    end
  endtask

  task automatic check_reset_outputs();
    check32("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check32("rst_imem_addr", bus.imem_addr, RESET_PC);
    check32("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check32("rst_if_pc", bus.if_pc, 32'd0);
    check32("rst_if_pc_plus4", bus.if_pc_plus4, 32'd4);
    check32("rst_if_instr", bus.if_instr, NOP);
    check32("rst_if_fault", 32'(bus.if_fault), 32'd0);
  endtask

  // Release lands just after an edge so the monitor sees cycle 0's request.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.stall = 1'b0;
    model_reset();
    #1 check_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs();
    rst = 1'b0;
  endtask

  task automatic redirect_to(logic [31:0] t);
    force_pc = t; force_red = 1'b1;
    step();
  endtask

  initial begin
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.stall = 1'b0;

    do_reset();
    step();
    check32("lat_cycle1_valid", 32'(bus.if_valid), 32'd0);
    step();
    check32("lat_cycle2_valid", 32'(bus.if_valid), 32'd1);
    check32("lat_cycle2_pc", bus.if_pc, RESET_PC);
    check32("lat_cycle2_pc4", bus.if_pc_plus4, RESET_PC + 32'd4);
    repeat (10) step();

    force_stall = 1'b1;
    repeat (5) step();
    check32("stall_req_off", 32'(bus.imem_req), 32'd0);
    check32("stall_valid", 32'(bus.if_valid), 32'd1);
    check32("stall_pc_held", bus.if_pc, exp_q[0].pc);
    force_stall = 1'b0;
    repeat (10) step();

    lat_min = 3; lat_max = 3;
    repeat (6) step();
    redirect_to(32'h0000_0100);
    repeat (20) step();

    lat_min = 1; lat_max = 1;
    repeat (5) step();
    redirect_to(32'h0000_0040);
    repeat (10) step();

    redirect_to(32'hFFFF_FFFC);
    repeat (10) step();

    redirect_to(32'h0000_0102);
    repeat (6) step();
    redirect_to(32'h0000_0200);
    repeat (10) step();

    p_red = 6; p_stall = 30; p_ready = 70; lat_min = 1; lat_max = 4;
    repeat (3000) step();

    do_reset();
    repeat (500) step();

    check32("progress", 32'(pops > 200), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
